// File: rtl/mem_responder.sv
// mem_responder
//   Data-side memory responder for the pipelined MIPS core. Serves the core's
//   data port from an on-chip word RAM and an MMIO window holding a byte
//   transmit FIFO (valid/ready drain), a GPIO output register and an optional
//   free-running cycle counter.
//
//   Address map (byte addresses, bits [1:0] ignored):
//     mem_addr[WIDTH-1] == 0 : RAM word mem_addr[RAM_WORDS_BITS+1:2] (upper bits alias)
//     mem_addr[WIDTH-1] == 1 : MMIO register mem_addr[3:2]
//       0 TXDATA  store pushes write_data[7:0], load returns 0
//       1 TXSTAT  {count @ [15:8], overflow @ 2, full @ 1, empty @ 0};
//                 store with write_data[2]=1 clears overflow
//       2 GPIO    read/write gpio_out
//       3 CYCLE   cycle counter (read-only)
//
//   Build option: define MEM_RESP_CYCLE_CNT_EN to build the cycle counter.
//   Without it no counter flops exist and CYCLE reads 0.
//
//   Ports:
//     clk, reset   single clock, synchronous active-high reset
//     mem_addr     byte address from core
//     mem_write    store strobe
//     write_data   store data
//     read_data    load data, combinational from mem_addr and current state
//     tx_data      registered FIFO head byte (0 while empty)
//     tx_valid     FIFO non-empty
//     tx_ready     sink accepts tx_data on tx_valid && tx_ready
//     gpio_out     GPIO register
module mem_responder #(
  parameter int WIDTH           = 32,
  parameter int RAM_WORDS_BITS  = 8,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [WIDTH-1:0] gpio_out
);

  localparam int RAM_WORDS  = 1 << RAM_WORDS_BITS;
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CNT_W      = FIFO_DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Status word layout for TXSTAT loads.
  function automatic logic [WIDTH-1:0] pack_stat(input logic [CNT_W-1:0] cnt,
                                                 input logic ovf,
                                                 input logic full,
                                                 input logic empty);
    logic [WIDTH-1:0] s;
    s             = '0;
    s[8 +: CNT_W] = cnt;
    s[2]          = ovf;
    s[1]          = full;
    s[0]          = empty;
    return s;
  endfunction

  // Address decode
  logic                      is_mmio;
  logic [RAM_WORDS_BITS-1:0] ram_idx;
  logic [1:0]                reg_idx;
  logic                      push_req;
  logic                      stat_wr;
  logic                      gpio_wr;

  assign is_mmio  = mem_addr[WIDTH-1];
  assign ram_idx  = mem_addr[RAM_WORDS_BITS+1:2];
  assign reg_idx  = mem_addr[3:2];
  assign push_req = mem_write && is_mmio && (reg_idx == 2'd0);
  assign stat_wr  = mem_write && is_mmio && (reg_idx == 2'd1);
  assign gpio_wr  = mem_write && is_mmio && (reg_idx == 2'd2);

  // Address bits that the decode deliberately ignores.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[1:0], mem_addr[WIDTH-2:RAM_WORDS_BITS+2]};

  // Word RAM: whole-word stores, combinational loads, never cleared.
  logic [WIDTH-1:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (mem_write && !is_mmio) begin
      ram[ram_idx] <= write_data;
    end
  end

  // Transmit FIFO
  logic [7:0]                 fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [CNT_W-1:0]           count;
  logic                       overflow;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       pop;
  logic                       push_acc;
  logic                       push_drop;
  logic [CNT_W-1:0]           count_nxt;
  logic [FIFO_DEPTH_BITS-1:0] rd_nxt;
  logic [7:0]                 head_nxt;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = !fifo_empty && tx_ready;
  // A push into a full FIFO only fits if the head leaves in the same cycle.
  assign push_acc   = push_req && (!fifo_full || pop);
  assign push_drop  = push_req && fifo_full && !pop;
  assign rd_nxt     = rd_ptr + FIFO_DEPTH_BITS'(pop);

  always_comb begin
    count_nxt = count;
    case ({push_acc, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Next head byte. When the new head is the slot being written this cycle
  // (push into an empty or just-emptied FIFO) it comes from write_data.
  always_comb begin
    head_nxt = '0;
    if (count_nxt != '0) begin
      if (push_acc && (rd_nxt == wr_ptr)) begin
        head_nxt = write_data[7:0];
      end else begin
        head_nxt = fifo_mem[rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc && !reset) begin
      fifo_mem[wr_ptr] <= write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      gpio_out <= '0;
    end else begin
      rd_ptr   <= rd_nxt;
      wr_ptr   <= wr_ptr + FIFO_DEPTH_BITS'(push_acc);
      count    <= count_nxt;
      tx_valid <= (count_nxt != '0);
      tx_data  <= head_nxt;
      // Set has priority over a clear in the same cycle.
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (stat_wr && write_data[2]) begin
        overflow <= 1'b0;
      end
      if (gpio_wr) begin
        gpio_out <= write_data;
      end
    end
  end

  // Cycle counter
  logic [WIDTH-1:0] cycle_val;

`ifdef MEM_RESP_CYCLE_CNT_EN
  logic [WIDTH-1:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign cycle_val = cycle_cnt;
`else
  assign cycle_val = '0;
`endif

  // Load mux
  always_comb begin
    read_data = '0;
    if (!is_mmio) begin
      read_data = ram[ram_idx];
    end else begin
      case (reg_idx)
        2'd1:    read_data = pack_stat(count, overflow, fifo_full, fifo_empty);
        2'd2:    read_data = gpio_out;
        2'd3:    read_data = cycle_val;
        default: read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Bench for mem_responder (default parameters). Directed scenarios followed
//   by randomized traffic, all compared against a queue/array reference model.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] gpio_out;

  mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .write_data (write_data),
    .read_data  (read_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .gpio_out   (gpio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  localparam int DEPTH = 4;
  logic [31:0] ram_m [256];
  bit          ram_v [256];
  logic [7:0]  fifo_q [$];
  bit          ovf_m;
  logic [31:0] gpio_m;
  logic [31:0] cyc_m;
  bit          model_valid = 0;

  function automatic bit model_known(input logic [31:0] a);
    if (!a[31]) return ram_v[a[9:2]];
    return model_valid;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int n;
    n = fifo_q.size();
    if (!a[31]) return ram_m[a[9:2]];
    case (a[3:2])
      2'd1:    return {16'h0, 8'(n), 5'b0, ovf_m, (n == DEPTH), (n == 0)};
      2'd2:    return gpio_m;
`ifdef MEM_RESP_CYCLE_CNT_EN
      2'd3:    return cyc_m;
`else
      2'd3:    return 32'h0;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_update(input logic [31:0] a, input logic we, input logic [31:0] wd,
                              input logic rdy, input logic rst);
    int pre;
    bit pop;
    bit push;
    pre  = fifo_q.size();
    pop  = (pre > 0) && rdy;
    push = we && a[31] && (a[3:2] == 2'd0);
    if (we && !a[31]) begin
      ram_m[a[9:2]] = wd;
      ram_v[a[9:2]] = 1;
    end
    if (rst) begin
      fifo_q.delete();
      ovf_m       = 0;
      gpio_m      = 0;
      cyc_m       = 0;
      model_valid = 1;
    end else begin
      cyc_m = cyc_m + 1;
      if (we && a[31] && (a[3:2] == 2'd1) && wd[2]) ovf_m = 0;
      if (we && a[31] && (a[3:2] == 2'd2)) gpio_m = wd;
      if (pop) void'(fifo_q.pop_front());
      if (push) begin
        if (pre == DEPTH && !pop) ovf_m = 1;
        else fifo_q.push_back(wd[7:0]);
      end
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the
  // pre-edge outputs, then advance the model at the rising edge.
  task automatic step(input logic [31:0] a, input logic we, input logic [31:0] wd,
                      input logic rdy, input logic rst,
                      output logic [31:0] rd_obs, output logic [7:0] txd_obs);
    @(negedge clk);
    mem_addr   = a;
    mem_write  = we;
    write_data = wd;
    tx_ready   = rdy;
    reset      = rst;
    #1;
    rd_obs  = read_data;
    txd_obs = tx_data;
    if (model_known(a)) check("read_data", read_data, model_read(a));
    if (model_valid) begin
      check("tx_valid", {31'b0, tx_valid}, {31'b0, fifo_q.size() != 0});
      check("tx_data", {24'b0, tx_data}, {24'b0, (fifo_q.size() != 0) ? fifo_q[0] : 8'h00});
      check("gpio_out", gpio_out, gpio_m);
    end
    @(posedge clk);
    model_update(a, we, wd, rdy, rst);
  endtask

  localparam logic [31:0] TXDATA = 32'h8000_0000;
  localparam logic [31:0] TXSTAT = 32'h8000_0004;
  localparam logic [31:0] GPIO   = 32'h8000_0008;
  localparam logic [31:0] CYCLE  = 32'h8000_000C;

  initial begin
    logic [31:0] rd;
    logic [7:0]  td;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [31:0] a;
    int          ri;

    mem_addr = 0; mem_write = 0; write_data = 0; tx_ready = 0; reset = 1;
    step(CYCLE, 0, 0, 0, 1, rd, td);
    step(CYCLE, 0, 0, 0, 1, rd, td);
    step(TXSTAT, 0, 0, 0, 0, rd, td);
    check("reset_stat", rd, 32'h0000_0001);

    // RAM store / next-cycle load / alias
    step(32'h10, 1, 32'hDEAD_BEEF, 0, 0, rd, td);
    step(32'h10, 0, 0, 0, 0, rd, td);
    check("ram_load", rd, 32'hDEAD_BEEF);
    step(32'h410, 0, 0, 0, 0, rd, td);
    check("ram_alias", rd, 32'hDEAD_BEEF);
    // same-cycle load sees old value
    step(32'h10, 1, 32'h1234_5678, 0, 0, rd, td);
    check("ram_no_bypass", rd, 32'hDEAD_BEEF);

    // FIFO order
    step(TXDATA, 1, 32'h11, 0, 0, rd, td);
    check("txdata_load", rd, 32'h0);
    step(TXDATA, 1, 32'h22, 0, 0, rd, td);
    step(TXDATA, 1, 32'h33, 0, 0, rd, td);
    step(TXSTAT, 0, 0, 0, 0, rd, td);
    check("stat_cnt3", rd, 32'h0000_0300);
    step(TXSTAT, 0, 0, 1, 0, rd, td);
    check("drain0", {24'b0, td}, 32'h11);
    step(TXSTAT, 0, 0, 1, 0, rd, td);
    check("drain1", {24'b0, td}, 32'h22);
    step(TXSTAT, 0, 0, 1, 0, rd, td);
    check("drain2", {24'b0, td}, 32'h33);
    step(TXSTAT, 0, 0, 1, 0, rd, td);
    check("drained_stat", rd, 32'h0000_0001);

    // Overflow
    for (int i = 0; i < 5; i++) step(TXDATA, 1, 32'hA0 + i, 0, 0, rd, td);
    step(TXSTAT, 0, 0, 0, 0, rd, td);
    check("ovf_stat", rd, 32'h0000_0406);
    step(TXSTAT, 1, 32'h4, 0, 0, rd, td);
    step(TXSTAT, 0, 0, 0, 0, rd, td);
    check("ovf_clr", rd, 32'h0000_0402);

    // Push while full with simultaneous pop
    step(TXDATA, 1, 32'h55, 1, 0, rd, td);
    check("full_pop_head", {24'b0, td}, 32'hA0);
    step(TXSTAT, 0, 0, 0, 0, rd, td);
    check("full_pop_stat", rd, 32'h0000_0402);
    for (int i = 0; i < 4; i++) step(TXSTAT, 0, 0, 1, 0, rd, td);
    check("last_55", {24'b0, td}, 32'h55);
    step(TXSTAT, 0, 0, 0, 0, rd, td);
    check("empty_again", rd, 32'h0000_0001);

    // GPIO and reset
    step(GPIO, 1, 32'hA5A5_0000, 0, 0, rd, td);
    step(GPIO, 0, 0, 0, 0, rd, td);
    check("gpio_read", rd, 32'hA5A5_0000);
    check("gpio_out", gpio_out, 32'hA5A5_0000);
    step(TXDATA, 1, 32'h77, 0, 0, rd, td);
    step(CYCLE, 0, 0, 1, 1, rd, td);
    step(CYCLE, 0, 0, 0, 0, rd, td);
    check("cycle_after_reset", rd, 32'h0);
    check("gpio_after_reset", gpio_out, 32'h0);
    check("txv_after_reset", {31'b0, tx_valid}, 32'h0);

    // Counter spacing
    step(CYCLE, 0, 0, 0, 0, rd, td);
    c0 = rd;
    for (int i = 0; i < 5; i++) step(32'h0, 0, 0, 0, 0, rd, td);
    step(CYCLE, 0, 0, 0, 0, rd, td);
    c1 = rd;
`ifdef MEM_RESP_CYCLE_CNT_EN
    check("cycle_delta", c1 - c0, 32'd6);
`else
    check("cycle_off0", c0, 32'h0);
    check("cycle_off1", c1, 32'h0);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      ri = $urandom_range(0, 9);
      if (ri < 4) begin
        a = ($urandom & 32'h7FFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      end else begin
        a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFF3) | (32'($urandom_range(0, 3)) << 2);
      end
      step(a, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) == 0),
           ($urandom_range(0, 59) == 0), rd, td);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
